mips_dmem_bridge: RTL and testbench



---
 rtl/mips_dmem_bridge.sv | 117 +++++++++++
 tb/tb_mips_dmem_bridge.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_dmem_bridge.sv
// Bridge from the CPU's single-cycle data port to a req/ack memory bus.
// Stalls the pipeline while a bus transaction is outstanding; timeout sets sticky err.
module mips_dmem_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] TIMEOUT_DATA   = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ext_en,
  output logic        cpu_en,
  input  logic [31:0] cpu_mem_addr,
  input  logic        cpu_mem_read_en,
  input  logic [3:0]  cpu_mem_write_en,
  input  logic [31:0] cpu_mem_write_data,
  output logic [31:0] cpu_mem_read_data,
  output logic        bus_req,
  output logic [3:0]  bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        err
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ?
    $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ?
    CW'(TIMEOUT_CYCLES - 1) : '0;
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);

  typedef enum logic {
    READY,
    WAIT
  } state_e;

  state_e        state_q, state_d;
  logic          req_q, req_d;
  logic [3:0]    we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^cpu_mem_addr[1:0];

  assign cpu_en            = ext_en & (state_q != WAIT);
  assign bus_req           = req_q;
  assign bus_we            = we_q;
  assign bus_addr          = addr_q;
  assign bus_wdata         = wdata_q;
  assign cpu_mem_read_data = rdata_q;
  assign err               = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= READY;
      req_q   <= 1'b0;
      we_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      READY: begin
        if (cpu_en && (cpu_mem_read_en || (|cpu_mem_write_en))) begin
          // Strobes win over read_en: any set strobe makes it a store.
          we_d    = cpu_mem_write_en;
          addr_d  = {cpu_mem_addr[31:2], 2'b00};
          wdata_d = cpu_mem_write_data;
          req_d   = 1'b1;
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus_ack) begin
          req_d   = 1'b0;
          state_d = READY;
          if (we_q == 4'b0000) rdata_d = bus_rdata;
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = READY;
          if (we_q == 4'b0000) rdata_d = TIMEOUT_DATA;
        end else if (TO_EN) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = READY;
    endcase
  end

endmodule

// File: tb/tb_mips_dmem_bridge.sv
// Self-checking bench for mips_dmem_bridge: vector table, random
// transactions against a transaction-level model, reset/enable corners.
module tb_mips_dmem_bridge;

  localparam int unsigned T = 6;
  localparam logic [32-1:0] TO_DATA = 32'hDEADBEEF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ext_en;
  logic        cpu_en;
  logic [31:0] cpu_mem_addr;
  logic        cpu_mem_read_en;
  logic [3:0]  cpu_mem_write_en;
  logic [31:0] cpu_mem_write_data;
  logic [31:0] cpu_mem_read_data;
  logic        bus_req;
  logic [3:0]  bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mips_dmem_bridge #(
    .TIMEOUT_CYCLES(T),
    .TIMEOUT_DATA  (TO_DATA)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .ext_en            (ext_en),
    .cpu_en            (cpu_en),
    .cpu_mem_addr      (cpu_mem_addr),
    .cpu_mem_read_en   (cpu_mem_read_en),
    .cpu_mem_write_en  (cpu_mem_write_en),
    .cpu_mem_write_data(cpu_mem_write_data),
    .cpu_mem_read_data (cpu_mem_read_data),
    .bus_req           (bus_req),
    .bus_we            (bus_we),
    .bus_addr          (bus_addr),
    .bus_wdata         (bus_wdata),
    .bus_ack           (bus_ack),
    .bus_rdata         (bus_rdata),
    .err               (err)
  );

  typedef struct {
    bit          rd;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;
    int          exp_stall;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Starts at a negedge in READY, returns at the negedge where cpu_en is back.
  task automatic do_txn(input bit rd, input logic [3:0] we,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int lat,
                        output int stall);
    int cyc;
    cpu_mem_read_en    = rd;
    cpu_mem_write_en   = we;
    cpu_mem_addr       = addr;
    cpu_mem_write_data = wdata;
    bus_ack            = 1'b0;
    chk("pre_cpu_en", {31'd0, cpu_en}, 32'd1);
    @(negedge clk);
    chk("req_rise", {31'd0, bus_req}, 32'd1);
    chk("bus_addr", bus_addr, {addr[31:2], 2'b00});
    chk("bus_we", {28'd0, bus_we}, {28'd0, we});
    chk("bus_wdata", bus_wdata, wdata);
    stall = 0;
    cyc = 1;
    while (cpu_en == 1'b0 && cyc < 50) begin
      stall++;
      chk("req_hold", {31'd0, bus_req}, 32'd1);
      bus_ack            = (cyc == lat);
      bus_rdata          = (cyc == lat) ? rdata : $urandom;
      cpu_mem_addr       = $urandom;
      cpu_mem_write_en   = 4'($urandom);
      cpu_mem_read_en    = 1'($urandom);
      cpu_mem_write_data = $urandom;
      @(negedge clk);
      cyc++;
    end
    bus_ack          = 1'b0;
    cpu_mem_read_en  = 1'b0;
    cpu_mem_write_en = 4'b0000;
    chk("done_cpu_en", {31'd0, cpu_en}, 32'd1);
    chk("done_req", {31'd0, bus_req}, 32'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int stall;
    int tot;
    bit rd;
    logic [3:0] we;
    logic [31:0] a, wd, rdv;
    int lat;
    logic [31:0] m_rdata;
    bit m_err;

    tbl[0] = '{1, 4'b0000, 32'h0000_0100, 32'h0, 32'h1234_5678, 1, 1,
               32'h1234_5678, 0};
    tbl[1] = '{0, 4'b0001, 32'h0000_1003, 32'hABAB_ABAB, 32'h5555_0000, 5, 5,
               32'h1234_5678, 0};
    tbl[2] = '{1, 4'b0000, 32'h0000_2000, 32'h0, 32'hCAFE_F00D, 2, 2,
               32'hCAFE_F00D, 0};
    tbl[3] = '{1, 4'b0000, 32'h0000_2004, 32'h0, 32'h0BAD_F00D, 2, 2,
               32'h0BAD_F00D, 0};
    tbl[4] = '{1, 4'b1111, 32'h0000_3002, 32'h0102_0304, 32'h9999_9999, 3, 3,
               32'h0BAD_F00D, 0};
    tbl[5] = '{1, 4'b0000, 32'h0000_4000, 32'h0, 32'h55AA_55AA, 6, 6,
               32'h55AA_55AA, 0};
    tbl[6] = '{1, 4'b0000, 32'h0000_5000, 32'h0, 32'h7777_7777, 99, 6,
               TO_DATA, 1};
    tbl[7] = '{1, 4'b0000, 32'h0000_6000, 32'h0, 32'h1111_2222, 1, 1,
               32'h1111_2222, 1};

    rst_n = 1'b0;
    ext_en = 1'b0;
    cpu_mem_addr = '0;
    cpu_mem_read_en = 1'b0;
    cpu_mem_write_en = '0;
    cpu_mem_write_data = '0;
    bus_ack = 1'b0;
    bus_rdata = '0;

    @(negedge clk);
    @(negedge clk);
    chk("rst_req", {31'd0, bus_req}, 32'd0);
    chk("rst_we", {28'd0, bus_we}, 32'd0);
    chk("rst_addr", bus_addr, 32'd0);
    chk("rst_wdata", bus_wdata, 32'd0);
    chk("rst_rdata", cpu_mem_read_data, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_cpu_en", {31'd0, cpu_en}, 32'd0);
    rst_n = 1'b1;
    ext_en = 1'b1;
    @(negedge clk);

    tot = 0;
    foreach (tbl[i]) begin
      do_txn(tbl[i].rd, tbl[i].we, tbl[i].addr, tbl[i].wdata,
             tbl[i].rdata, tbl[i].lat, stall);
      chk($sformatf("tbl%0d_stall", i), stall, tbl[i].exp_stall);
      chk($sformatf("tbl%0d_rdata", i), cpu_mem_read_data, tbl[i].exp_rdata);
      chk($sformatf("tbl%0d_err", i), {31'd0, err}, {31'd0, tbl[i].exp_err});
      if (i == 2 || i == 3) tot += stall;
    end
    chk("b2b_total_stall", tot, 4);

    // Random phase: model works per transaction, not per cycle.
    pulse_reset();
    m_rdata = '0;
    m_err = 1'b0;
    for (int n = 0; n < 60; n++) begin
      rd  = 1'($urandom);
      we  = rd ? 4'($urandom_range(0, 1) * $urandom) : 4'($urandom_range(1, 15));
      a   = $urandom;
      wd  = $urandom;
      rdv = $urandom;
      lat = $urandom_range(1, T + 2);
      do_txn(rd, we, a, wd, rdv, lat, stall);
      if (lat > int'(T)) m_err = 1'b1;
      if (we == 4'b0000) m_rdata = (lat > int'(T)) ? TO_DATA : rdv;
      chk("rnd_stall", stall, (lat > int'(T)) ? int'(T) : lat);
      chk("rnd_rdata", cpu_mem_read_data, m_rdata);
      chk("rnd_err", {31'd0, err}, {31'd0, m_err});
    end

    // Ensure a nonzero read value, then reset in the middle of WAIT.
    do_txn(1, 4'b0000, 32'h8000_0000, 32'h0, 32'hA5A5_0001, 1, stall);
    chk("pre_rst_rdata", cpu_mem_read_data, 32'hA5A5_0001);
    cpu_mem_read_en = 1'b1;
    cpu_mem_addr = 32'h8000_0010;
    @(negedge clk);
    chk("mid_req", {31'd0, bus_req}, 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_req", {31'd0, bus_req}, 32'd0);
    chk("async_rdata", cpu_mem_read_data, 32'd0);
    chk("async_cpu_en", {31'd0, cpu_en}, 32'd1);
    @(negedge clk);
    cpu_mem_read_en = 1'b0;
    rst_n = 1'b1;
    bus_ack = 1'b1;
    bus_rdata = 32'h0000_0077;
    @(negedge clk);
    @(negedge clk);
    bus_ack = 1'b0;
    chk("late_ack_req", {31'd0, bus_req}, 32'd0);
    chk("late_ack_rdata", cpu_mem_read_data, 32'd0);
    chk("late_ack_cpu_en", {31'd0, cpu_en}, 32'd1);

    // ext_en low with a request present, plus spurious ack.
    ext_en = 1'b0;
    cpu_mem_read_en = 1'b1;
    cpu_mem_write_en = 4'b0011;
    bus_ack = 1'b1;
    bus_rdata = 32'h0000_0066;
    #1 chk("exten0_cpu_en", {31'd0, cpu_en}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("exten0_req", {31'd0, bus_req}, 32'd0);
    chk("exten0_we", {28'd0, bus_we}, 32'd0);
    chk("exten0_rdata", cpu_mem_read_data, 32'd0);
    bus_ack = 1'b0;
    cpu_mem_write_en = 4'b0000;
    ext_en = 1'b1;

    // ext_en drops during WAIT: transaction still completes.
    cpu_mem_read_en = 1'b1;
    cpu_mem_addr = 32'h0000_0A04;
    @(negedge clk);
    chk("exten_wait_req", {31'd0, bus_req}, 32'd1);
    ext_en = 1'b0;
    @(negedge clk);
    bus_ack = 1'b1;
    bus_rdata = 32'h3C3C_3C3C;
    @(negedge clk);
    bus_ack = 1'b0;
    chk("exten_done_req", {31'd0, bus_req}, 32'd0);
    chk("exten_done_rdata", cpu_mem_read_data, 32'h3C3C_3C3C);
    chk("exten_done_cpu_en", {31'd0, cpu_en}, 32'd0);
    @(negedge clk);
    chk("exten_no_capture", {31'd0, bus_req}, 32'd0);
    cpu_mem_read_en = 1'b0;
    ext_en = 1'b1;
    #1 chk("exten_back", {31'd0, cpu_en}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
